// File: rtl/sdram_arb_pkg.sv
// Shared constants, FSM state type and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } state_t;

    // Position of the set bit in a one-hot vector of up to 8 ports (0 when empty).
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Round-robin picker: first request at or after ptr+1 (wrapping) wins, reported one-hot.
module rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             valid
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < N; i++) begin
            idx = (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NUM_PORTS requesters.
// Define SDRAM_ARB_PRIORITY_EN to give port 0 strict priority over the round-robin ports.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int BURST_LEN = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_address,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_data_write,
    output logic [NUM_PORTS-1:0]              grant,
    output logic [NUM_PORTS-1:0]              port_data_next,
    output logic [NUM_PORTS-1:0]              port_data_ready,
    output logic [DATA_W-1:0]                 port_data_read,
    output logic [NUM_PORTS-1:0]              port_done,
    output logic [1:0]                        command,
    output logic [ADDR_W-1:0]                 data_address,
    output logic [DATA_W-1:0]                 data_write,
    input  logic [DATA_W-1:0]                 data_read,
    input  logic                              data_ready,
    input  logic                              data_next,
    output logic [1:0]                        fsm_state
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     winner_q, ptr_q, win_idx;
    logic                 write_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_PORTS-1:0] pick_req, pick_oh, win_oh, win_sel;
    logic                 pick_valid, win_valid, ptr_load;
    logic                 active, beat, last_beat;

    rr_picker #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_picker (
        .req    (pick_req),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

`ifdef SDRAM_ARB_PRIORITY_EN
    // Port 0 bypasses the rotation and never moves the pointer.
    assign pick_req  = {req[NUM_PORTS-1:1], 1'b0};
    assign win_oh    = req[0] ? NUM_PORTS'(1) : pick_oh;
    assign win_valid = req[0] | pick_valid;
    assign ptr_load  = (winner_q != '0);
`else
    assign pick_req  = req;
    assign win_oh    = pick_oh;
    assign win_valid = pick_valid;
    assign ptr_load  = 1'b1;
`endif

    assign win_idx = PTR_W'(oh_to_idx(8'(win_oh)));
    assign win_sel = NUM_PORTS'(1) << winner_q;

    // A beat is a single-cycle strobe from the controller (data_next for writes,
    // data_ready for reads); it only counts while a transaction owns the controller
    // and only when it matches the latched direction.
    assign active    = (state_q == ISSUE) || (state_q == BURST);
    assign beat      = active && (write_q ? data_next : data_ready);
    assign last_beat = beat && (cnt_q == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = ISSUE;
            ISSUE:   if (beat) state_d = last_beat ? IDLE : BURST;
            BURST:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            ptr_q    <= PTR_W'(NUM_PORTS - 1);
            cnt_q    <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
            if (win_valid) begin
                winner_q <= win_idx;
                write_q  <= req_write[win_idx];
                addr_q   <= req_address[win_idx];
            end
        end else if (last_beat) begin
            cnt_q <= '0;
            if (ptr_load) ptr_q <= winner_q;
        end else if (beat) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        command         = CMD_IDLE;
        data_address    = '0;
        grant           = '0;
        port_data_next  = '0;
        port_data_ready = '0;
        port_done       = '0;
        if (state_q == ISSUE) begin
            command      = write_q ? CMD_WRITE : CMD_READ;
            data_address = addr_q;
        end
        if (active) grant = win_sel;
        if (active && write_q && data_next) port_data_next = win_sel;
        if (active && !write_q && data_ready) port_data_ready = win_sel;
        if (last_beat) port_done = win_sel;
    end

    assign data_write     = req_data_write[winner_q];
    assign port_data_read = data_read;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: random requesters, a controller model that checks each
// issued transaction against a queue of expected grants predicted from the arbitration rules.
module tb_sdram_arbiter;

    localparam int NP = 3;
    localparam int BL = 2;
    localparam int AW = 22;
    localparam int DW = 16;

    typedef struct packed {
        logic [1:0]            port;
        logic                  wr;
        logic [AW-1:0]         addr;
        logic [BL-1:0][DW-1:0] data;
    } txn_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NP-1:0]         req, req_write;
    logic [NP-1:0][AW-1:0] req_address;
    logic [NP-1:0][DW-1:0] req_data_write;
    logic [NP-1:0]         grant, port_data_next, port_data_ready, port_done;
    logic [DW-1:0]         port_data_read, data_write, data_read;
    logic [1:0]            command, fsm_state;
    logic [AW-1:0]         data_address;
    logic                  data_ready, data_next;
    logic                  drv_next_c, drv_ready_c, drv_next_m;

    assign data_next  = drv_next_c | drv_next_m;
    assign data_ready = drv_ready_c;

    txn_t                  exp_q[$];
    int                    total, bad, model_ptr;
    bit                    ctrl_en;
    logic [BL-1:0][DW-1:0] port_wdata [NP];

    sdram_arbiter #(.NUM_PORTS(NP), .BURST_LEN(BL)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_data_write  (req_data_write),
        .grant           (grant),
        .port_data_next  (port_data_next),
        .port_data_ready (port_data_ready),
        .port_data_read  (port_data_read),
        .port_done       (port_done),
        .command         (command),
        .data_address    (data_address),
        .data_write      (data_write),
        .data_read       (data_read),
        .data_ready      (data_ready),
        .data_next       (data_next),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / reference model ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Next winner among pending ports given the model pointer.
    function automatic int rr_pick(input logic [NP-1:0] pend);
        int c;
`ifdef SDRAM_ARB_PRIORITY_EN
        if (pend[0]) return 0;
`endif
        for (int k = 1; k <= NP; k++) begin
            c = (model_ptr + k) % NP;
`ifdef SDRAM_ARB_PRIORITY_EN
            if (c != 0 && pend[c]) return c;
`else
            if (pend[c]) return c;
`endif
        end
        return 0;
    endfunction

    task automatic setup_port(input int p, input logic wr, input logic [AW-1:0] addr,
                              input logic [BL-1:0][DW-1:0] d);
        req_write[p]      = wr;
        req_address[p]    = addr;
        port_wdata[p]     = d;
        req_data_write[p] = d[0];
    endtask

    task automatic rand_setup(input int p);
        logic [BL-1:0][DW-1:0] d;
        for (int b = 0; b < BL; b++) d[b] = DW'($urandom);
        setup_port(p, 1'($urandom_range(0, 1)), AW'($urandom), d);
    endtask

    // Predicts the service order for a set of simultaneous requests, raises them,
    // and plays the requester side until every port in the mask has finished.
    task automatic launch(input logic [NP-1:0] mask);
        logic [NP-1:0] pend, done_m, scr, adv;
        int            bidx [NP];
        txn_t          t;
        int            w, cyc;
        pend = mask;
        while (pend != '0) begin
            w      = rr_pick(pend);
            t.port = 2'(w);
            t.wr   = req_write[w];
            t.addr = req_address[w];
            t.data = port_wdata[w];
            exp_q.push_back(t);
            pend[w] = 1'b0;
`ifdef SDRAM_ARB_PRIORITY_EN
            if (w != 0) model_ptr = w;
`else
            model_ptr = w;
`endif
        end
        for (int p = 0; p < NP; p++) bidx[p] = 0;
        done_m = '0;
        scr    = '0;
        adv    = '0;
        cyc    = 0;
        @(negedge clk);
        req = mask;
        while (done_m != mask && cyc < 200) begin
            #2;
            for (int p = 0; p < NP; p++) begin
                if (port_data_next[p]) adv[p] = 1'b1;
                if (port_done[p]) begin
                    done_m[p] = 1'b1;
                    req[p]    = 1'b0;
                end
                if (grant[p] && !scr[p]) begin
                    // Latched fields must not follow these changes.
                    scr[p]         = 1'b1;
                    req_write[p]   = ~req_write[p];
                    req_address[p] = AW'($urandom);
                    if ($urandom_range(0, 2) == 0) req[p] = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (adv[p]) begin
                    adv[p] = 1'b0;
                    bidx[p]++;
                    if (bidx[p] < BL) req_data_write[p] = port_wdata[p][bidx[p]];
                end
            end
        end
        if (done_m != mask) begin
            check("round_done", 64'(done_m), 64'(mask));
            exp_q.delete();
            req = '0;
        end
    endtask

    // ---------------- controller model / monitor ----------------
    initial begin : ctrl
        txn_t          t;
        logic [NP-1:0] oh;
        int            gaps;
        logic [DW-1:0] rd;
        drv_next_c  = 1'b0;
        drv_ready_c = 1'b0;
        data_read   = '0;
        forever begin
            @(negedge clk);
            drv_next_c  = 1'b0;
            drv_ready_c = 1'b0;
            if (!ctrl_en || reset) continue;
            if (command == 2'd0) begin
                if ($urandom_range(0, 3) == 0) begin
                    drv_ready_c = 1'b1;
                    drv_next_c  = 1'($urandom_range(0, 1));
                    #1;
                    check("idle_stray", 64'({port_data_next, port_data_ready, port_done}), 64'(0));
                end
            end else if (exp_q.size() == 0) begin
                check("unexpected_cmd", 64'(command), 64'(0));
            end else begin
                t  = exp_q.pop_front();
                oh = NP'(1) << t.port;
                check("issue_grant", 64'(grant), 64'(oh));
                check("issue_cmd", 64'(command), t.wr ? 64'(1) : 64'(2));
                check("issue_addr", 64'(data_address), 64'(t.addr));
                for (int b = 0; b < BL; b++) begin
                    gaps = $urandom_range(0, 2);
                    for (int g = 0; g < gaps; g++) begin
                        if (t.wr) drv_ready_c = 1'($urandom_range(0, 1));
                        else      drv_next_c  = 1'($urandom_range(0, 1));
                        data_read = DW'($urandom);
                        #1;
                        check("gap_strobes", 64'({port_data_next, port_data_ready, port_done}), 64'(0));
                        check("gap_grant", 64'(grant), 64'(oh));
                        check("gap_cmd", 64'(command), (b == 0) ? (t.wr ? 64'(1) : 64'(2)) : 64'(0));
                        @(negedge clk);
                        drv_next_c  = 1'b0;
                        drv_ready_c = 1'b0;
                    end
                    rd = DW'($urandom);
                    if (t.wr) drv_next_c = 1'b1;
                    else begin
                        drv_ready_c = 1'b1;
                        data_read   = rd;
                    end
                    #1;
                    if (t.wr) begin
                        check("wr_next", 64'(port_data_next), 64'(oh));
                        check("wr_ready", 64'(port_data_ready), 64'(0));
                        check("wr_data", 64'(data_write), 64'(t.data[b]));
                    end else begin
                        check("rd_ready", 64'(port_data_ready), 64'(oh));
                        check("rd_next", 64'(port_data_next), 64'(0));
                        check("rd_data", 64'(port_data_read), 64'(rd));
                    end
                    check("beat_grant", 64'(grant), 64'(oh));
                    check("beat_done", 64'(port_done), (b == BL - 1) ? 64'(oh) : 64'(0));
                    @(negedge clk);
                    drv_next_c  = 1'b0;
                    drv_ready_c = 1'b0;
                    check("post_beat_cmd", 64'(command), 64'(0));
                end
                #1;
                check("between_grant", 64'(grant), 64'(0));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [NP-1:0] m;
        int            cyc;
        reset          = 1'b1;
        req            = '0;
        req_write      = '0;
        req_address    = '0;
        req_data_write = '0;
        drv_next_m     = 1'b0;
        ctrl_en        = 1'b0;
        total          = 0;
        bad            = 0;
        model_ptr      = NP - 1;
        repeat (3) @(negedge clk);
        check("rst_command", 64'(command), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_addr", 64'(data_address), 64'(0));
        check("rst_strobes", 64'({port_data_next, port_data_ready, port_done}), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(0));
        reset   = 1'b0;
        ctrl_en = 1'b1;
        repeat (2) @(negedge clk);

        // Port 1 write alone, then port 0 read at the top address.
        setup_port(1, 1'b1, 22'h000100, {16'hBEEF, 16'hFACE});
        launch(3'b010);
        setup_port(0, 1'b0, 22'h3FFFFF, {16'h0000, 16'h0000});
        launch(3'b001);

        // Two ports contending repeatedly.
        for (int r = 0; r < 4; r++) begin
            rand_setup(0);
            rand_setup(1);
            launch(3'b011);
        end

        // Random request sets.
        for (int r = 0; r < 30; r++) begin
            m = NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) rand_setup(p);
            launch(m);
        end
        rand_setup(1);
        launch(3'b010);

        // Reset in the middle of a burst.
        ctrl_en = 1'b0;
        @(negedge clk);
        setup_port(1, 1'b1, 22'h02A5A5, {16'h1234, 16'h5678});
        req = 3'b010;
        cyc = 0;
        while (command == 2'd0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_issue_seen", 64'(command), 64'(1));
        drv_next_m = 1'b1;
        @(negedge clk);
        check("rst_in_burst", 64'(fsm_state), 64'(2));
        #1;
        check("rst_pre_strobe", 64'(port_data_next), 64'(3'b010));
        reset = 1'b1;
        #1;
        check("rst_mid_cmd", 64'(command), 64'(0));
        check("rst_mid_grant", 64'(grant), 64'(0));
        check("rst_mid_strobes", 64'({port_data_next, port_data_ready, port_done}), 64'(0));
        check("rst_mid_state", 64'(fsm_state), 64'(0));
        drv_next_m = 1'b0;
        req        = '0;
        @(negedge clk);
        reset     = 1'b0;
        model_ptr = NP - 1;
        exp_q.delete();
        ctrl_en = 1'b1;
        @(negedge clk);
        for (int p = 0; p < NP; p++) rand_setup(p);
        launch('1);

        repeat (5) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
